// File: rtl/dcpu_bus_pkg.sv
// rtl/dcpu_bus_pkg.sv - shared types and constants for the dcpu bus arbiter
package dcpu_bus_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  // Read data returned to a master whose transaction was killed by the watchdog
  localparam logic [DATA_W-1:0] BUS_ERR_DATA = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/dcpu_bus_arbiter_if.sv
// rtl/dcpu_bus_arbiter_if.sv - requester-side and slave-side bus bundle for the arbiter
interface dcpu_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import dcpu_bus_pkg::*;

  logic [NUM_MASTERS-1:0]        i_m_cs;
  logic [NUM_MASTERS-1:0]        i_m_we;
  logic [ADDR_W*NUM_MASTERS-1:0] i_m_addr;
  logic [DATA_W*NUM_MASTERS-1:0] i_m_dat;
  logic [DATA_W-1:0]             o_m_dat;
  logic [NUM_MASTERS-1:0]        o_m_ack;

  logic                          o_s_cs;
  logic                          o_s_we;
  logic [ADDR_W-1:0]             o_s_addr;
  logic [DATA_W-1:0]             o_s_dat;
  logic [DATA_W-1:0]             i_s_dat;
  logic                          i_s_ack;

  logic [NUM_MASTERS-1:0]        o_grant;
  logic                          o_timeout;

  // Environment side: requesters and the memory/peripheral decoder
  modport master (
    output i_m_cs, i_m_we, i_m_addr, i_m_dat, i_s_dat, i_s_ack,
    input  o_m_dat, o_m_ack, o_s_cs, o_s_we, o_s_addr, o_s_dat, o_grant, o_timeout
  );

  // Arbiter side
  modport slave (
    input  i_m_cs, i_m_we, i_m_addr, i_m_dat, i_s_dat, i_s_ack,
    output o_m_dat, o_m_ack, o_s_cs, o_s_we, o_s_addr, o_s_dat, o_grant, o_timeout
  );

endinterface

// File: rtl/dcpu_rr_pick.sv
// rtl/dcpu_rr_pick.sv - combinational round-robin picker starting after the last winner
module dcpu_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int           start;
  logic [N-1:0] rot;

  // Rotating the doubled vector puts the highest-priority requester at bit 0
  always_comb begin
    start = (int'(last) + 1) % N;
    rot   = N'({req, req} >> start);
    valid = 1'b0;
    idx   = '0;
    grant = '0;
    for (int p = 0; p < N; p++) begin
      if (rot[p] && !valid) begin
        valid = 1'b1;
        idx   = IDX_W'((start + p) % N);
      end
    end
    if (valid) begin
      grant = N'(1) << idx;
    end
  end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// rtl/dcpu_bus_arbiter.sv - round-robin arbiter with transaction lock and watchdog for the shared memory bus
module dcpu_bus_arbiter
  import dcpu_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  dcpu_bus_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   g_cs, g_we;
  logic [ADDR_W-1:0]      g_addr;
  logic [DATA_W-1:0]      g_dat;
  logic                   wdog_fire;

  logic                   s_cs, s_we;
  logic [ADDR_W-1:0]      s_addr;
  logic [DATA_W-1:0]      s_dat;
  logic [NUM_MASTERS-1:0] m_ack;
  logic [DATA_W-1:0]      m_dat;
  logic                   timeout_pulse;

  dcpu_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.i_m_cs),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign g_cs      = bus.i_m_cs[gidx_q];
  assign g_we      = bus.i_m_we[gidx_q];
  assign g_addr    = bus.i_m_addr[gidx_q*ADDR_W +: ADDR_W];
  assign g_dat     = bus.i_m_dat[gidx_q*DATA_W +: DATA_W];
  assign wdog_fire = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    s_cs          = 1'b0;
    s_we          = 1'b0;
    s_addr        = '0;
    s_dat         = '0;
    m_ack         = '0;
    m_dat         = '0;
    timeout_pulse = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        s_cs   = g_cs;
        s_we   = g_we;
        s_addr = g_addr;
        s_dat  = g_dat;
        if (!g_cs || bus.i_s_ack || wdog_fire) begin
          // Abort, completion and watchdog all release the bus the same way
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
          cnt_d   = '0;
          if (g_cs) begin
            m_ack = grant_q;
            if (bus.i_s_ack) begin
              m_dat = bus.i_s_dat;
            end else begin
              m_dat         = BUS_ERR_DATA;
              timeout_pulse = 1'b1;
            end
          end
        end else if (TIMEOUT > 0 && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.o_s_cs    = s_cs;
  assign bus.o_s_we    = s_we;
  assign bus.o_s_addr  = s_addr;
  assign bus.o_s_dat   = s_dat;
  assign bus.o_m_ack   = m_ack;
  assign bus.o_m_dat   = m_dat;
  assign bus.o_grant   = grant_q;
  assign bus.o_timeout = timeout_pulse;

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// tb/tb_dcpu_bus_arbiter.sv - self-checking bench for dcpu_bus_arbiter against a transaction-level model
module tb_dcpu_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: whether a transaction is open, who owns it, how old it is
  bit   m_busy, nx_busy;
  int   m_g, nx_g, m_last, nx_last, m_age, nx_age;

  logic [N-1:0]  exp_grant, exp_ack;
  logic          exp_scs, exp_swe, exp_to;
  logic [15:0]   exp_saddr, exp_sdat, exp_mdat;
  logic [N-1:0]  prev_grant;

  always #5 clk = ~clk;

  dcpu_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  dcpu_bus_arbiter #(
    .NUM_MASTERS (N),
    .TIMEOUT     (TO)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic set_m(input int k, input logic cs, input logic we,
                       input logic [15:0] addr, input logic [15:0] dat);
    bus.i_m_cs[k]            = cs;
    bus.i_m_we[k]            = we;
    bus.i_m_addr[16*k +: 16] = addr;
    bus.i_m_dat[16*k +: 16]  = dat;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_last = N - 1;
    m_age  = 0;
  endtask

  task automatic model_eval();
    exp_grant = '0; exp_ack = '0; exp_scs = 1'b0; exp_swe = 1'b0; exp_to = 1'b0;
    exp_saddr = '0; exp_sdat = '0; exp_mdat = '0;
    nx_busy = m_busy; nx_g = m_g; nx_last = m_last; nx_age = m_age + 1;
    if (!m_busy) begin
      // First requester after the previous owner, wrapping around
      for (int k = 1; k <= N; k++) begin
        int m;
        m = (m_last + k) % N;
        if (bus.i_m_cs[m] && !nx_busy) begin
          nx_busy = 1'b1;
          nx_g    = m;
          nx_age  = 1;
        end
      end
    end else begin
      exp_grant[m_g] = 1'b1;
      exp_scs        = bus.i_m_cs[m_g];
      exp_swe        = bus.i_m_we[m_g];
      exp_saddr      = bus.i_m_addr[16*m_g +: 16];
      exp_sdat       = bus.i_m_dat[16*m_g +: 16];
      if (!bus.i_m_cs[m_g] || bus.i_s_ack || m_age == TO) begin
        nx_busy = 1'b0;
        nx_last = m_g;
      end
      if (bus.i_m_cs[m_g] && bus.i_s_ack) begin
        exp_ack[m_g] = 1'b1;
        exp_mdat     = bus.i_s_dat;
      end else if (bus.i_m_cs[m_g] && m_age == TO) begin
        exp_ack[m_g] = 1'b1;
        exp_mdat     = 16'hFFFF;
        exp_to       = 1'b1;
      end
    end
  endtask

  task automatic sample();
    #1;
    model_eval();
    chk("grant",   32'(bus.o_grant),   32'(exp_grant));
    chk("s_cs",    32'(bus.o_s_cs),    32'(exp_scs));
    chk("s_we",    32'(bus.o_s_we),    32'(exp_swe));
    chk("s_addr",  32'(bus.o_s_addr),  32'(exp_saddr));
    chk("s_dat",   32'(bus.o_s_dat),   32'(exp_sdat));
    chk("m_ack",   32'(bus.o_m_ack),   32'(exp_ack));
    chk("m_dat",   32'(bus.o_m_dat),   32'(exp_mdat));
    chk("timeout", 32'(bus.o_timeout), 32'(exp_to));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      m_busy = nx_busy; m_g = nx_g; m_last = nx_last; m_age = nx_age;
    end
    @(negedge clk);
  endtask

  // Masters hold cs until acked, occasionally abort; slave acks at random
  task automatic drive_random();
    for (int k = 0; k < N; k++) begin
      if (!bus.i_m_cs[k] || exp_ack[k]) begin
        if ($urandom_range(0, 3) == 0)
          set_m(k, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        else
          bus.i_m_cs[k] = 1'b0;
      end else if ($urandom_range(0, 31) == 0) begin
        bus.i_m_cs[k] = 1'b0;
      end
    end
    bus.i_s_ack = ($urandom_range(0, 2) == 0);
    bus.i_s_dat = 16'($urandom);
  endtask

  initial begin
    bus.i_m_cs = '0; bus.i_m_we = '0; bus.i_m_addr = '0; bus.i_m_dat = '0;
    bus.i_s_dat = '0; bus.i_s_ack = 1'b0;
    model_reset();
    exp_ack = '0;

    #12;
    chk("rst_grant", 32'(bus.o_grant),   32'd0);
    chk("rst_s_cs",  32'(bus.o_s_cs),    32'd0);
    chk("rst_m_ack", 32'(bus.o_m_ack),   32'd0);
    chk("rst_m_dat", 32'(bus.o_m_dat),   32'd0);
    chk("rst_to",    32'(bus.o_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single master read, slave acks two cycles after cs
    set_m(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    bus.i_s_dat = 16'h1234;
    sample(); advance();
    sample();
    chk("t1_s_cs_n1", 32'(bus.o_s_cs), 32'd1);
    chk("t1_s_addr",  32'(bus.o_s_addr), 32'h0100);
    advance();
    sample(); advance();
    bus.i_s_ack = 1'b1;
    sample();
    chk("t1_ack",   32'(bus.o_m_ack), 32'b001);
    chk("t1_m_dat", 32'(bus.o_m_dat), 32'h1234);
    advance();
    set_m(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    bus.i_s_ack = 1'b0;
    sample();
    chk("t1_grant_clr", 32'(bus.o_grant), 32'd0);
    advance();

    // Contention between masters 0 and 1 with immediate acks
    set_m(0, 1'b1, 1'b0, 16'h0200, 16'h0000);
    set_m(1, 1'b1, 1'b0, 16'h0300, 16'h0000);
    bus.i_s_ack = 1'b1;
    prev_grant  = '0;
    repeat (12) begin
      sample();
      chk("t2_stray_ack", 32'(bus.o_m_ack & ~bus.o_grant), 32'd0);
      if (bus.o_grant != '0) begin
        if (prev_grant != '0) chk("t2_alternate", 32'(bus.o_grant), 32'(prev_grant ^ 3'b011));
        prev_grant = bus.o_grant;
      end
      advance();
    end
    bus.i_m_cs = '0; bus.i_s_ack = 1'b0;
    sample(); advance();

    // Write passthrough from master 1 while master 0 waits
    set_m(1, 1'b1, 1'b1, 16'h8000, 16'hBEEF);
    sample(); advance();
    set_m(0, 1'b1, 1'b1, 16'h1111, 16'h2222);
    sample();
    chk("t3_grant",  32'(bus.o_grant),  32'b010);
    chk("t3_s_we",   32'(bus.o_s_we),   32'd1);
    chk("t3_s_addr", 32'(bus.o_s_addr), 32'h8000);
    chk("t3_s_dat",  32'(bus.o_s_dat),  32'hBEEF);
    advance();
    bus.i_s_ack = 1'b1;
    sample(); chk("t3_ack", 32'(bus.o_m_ack), 32'b010); advance();
    set_m(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    sample(); advance();
    sample(); advance();
    bus.i_m_cs = '0; bus.i_s_ack = 1'b0;
    sample(); advance();

    // Watchdog fires on the fourth busy cycle
    set_m(0, 1'b1, 1'b0, 16'h0400, 16'h0000);
    sample(); advance();
    repeat (3) begin sample(); chk("t4_no_to", 32'(bus.o_timeout), 32'd0); advance(); end
    sample();
    chk("t4_ack", 32'(bus.o_m_ack),   32'b001);
    chk("t4_dat", 32'(bus.o_m_dat),   32'hFFFF);
    chk("t4_to",  32'(bus.o_timeout), 32'd1);
    advance();
    bus.i_m_cs = '0;
    sample(); advance();
    set_m(0, 1'b1, 1'b0, 16'h0404, 16'h0000);
    sample(); advance();
    repeat (3) begin sample(); advance(); end
    bus.i_s_ack = 1'b1; bus.i_s_dat = 16'h5A5A;
    sample();
    chk("t4b_ack", 32'(bus.o_m_ack),   32'b001);
    chk("t4b_dat", 32'(bus.o_m_dat),   32'h5A5A);
    chk("t4b_to",  32'(bus.o_timeout), 32'd0);
    advance();
    bus.i_m_cs = '0; bus.i_s_ack = 1'b0;
    sample(); advance();

    // Abort with a coincident slave ack
    set_m(0, 1'b1, 1'b0, 16'h0500, 16'h0000);
    set_m(1, 1'b1, 1'b0, 16'h0600, 16'h0000);
    sample(); advance();
    sample(); chk("t5_grant", 32'(bus.o_grant), 32'b010); advance();
    bus.i_m_cs[1] = 1'b0; bus.i_s_ack = 1'b1;
    sample();
    chk("t5_no_ack", 32'(bus.o_m_ack), 32'd0);
    chk("t5_s_cs",   32'(bus.o_s_cs),  32'd0);
    advance();
    bus.i_s_ack = 1'b0;
    sample(); advance();
    sample(); chk("t5_next", 32'(bus.o_grant), 32'b001);

    // Asynchronous reset in the middle of a busy cycle
    bus.i_m_cs[1] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_s_cs",  32'(bus.o_s_cs),  32'd0);
    chk("t6_grant", 32'(bus.o_grant), 32'd0);
    chk("t6_ack",   32'(bus.o_m_ack), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sample(); advance();
    sample(); chk("t6_first", 32'(bus.o_grant), 32'b001); advance();

    // Randomized traffic
    bus.i_m_cs = '0; bus.i_s_ack = 1'b0;
    repeat (3000) begin
      drive_random();
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
